// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_ctrl
//  Description : Runtime-configurable sequencer for the 4-LED board display.
//                Four step patterns, four speeds, pause/resume, driven by
//                single-cycle key pulses from the key debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
   parameter int TICK_BASE = 12_500_000   // base tick period in clk cycles
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_mode,
   input  logic       key_up,
   input  logic       key_dn,
   input  logic       key_pause,
   output logic [3:0] led,
   output logic [1:0] mode,
   output logic [1:0] speed,
   output logic       paused
);

   // Terminal count of the prescaler; TICK_BASE up to 2^24 still fits.
   localparam logic [23:0] TICK_LAST = 24'(TICK_BASE - 1);

   logic [23:0] base_cnt;
   logic [1:0]  step_cnt;
   logic [2:0]  pos;

   logic        base_tick;
   logic        run;
   logic [1:0]  step_thr;
   logic        step_fire;
   logic [2:0]  pos_last;
   logic [2:0]  pos_adv;
   logic [3:0]  pattern;

   // Tick/step decode. The step threshold shrinks as speed rises; using >=
   // means a speed-up that lands below the current count fires at once.
   always_comb begin
      run       = ~paused;
      base_tick = (base_cnt == TICK_LAST);
      step_thr  = 2'd3 - speed;
      step_fire = run & base_tick & (step_cnt >= step_thr);
   end

   // Per-mode last position and the wrapped position advance.
   always_comb begin
      pos_last = 3'd3;
      case (mode)
         2'd0:    pos_last = 3'd3;
         2'd1:    pos_last = 3'd3;
         2'd2:    pos_last = 3'd5;
         default: pos_last = 3'd1;
      endcase
      pos_adv = (pos >= pos_last) ? 3'd0 : pos + 3'd1;
   end

   // Pattern lookup from the current mode and position.
   always_comb begin
      pattern = 4'b0000;
      case (mode)
         2'd0: begin
            case (pos)
               3'd0:    pattern = 4'b1000;
               3'd1:    pattern = 4'b0100;
               3'd2:    pattern = 4'b0010;
               3'd3:    pattern = 4'b0001;
               default: pattern = 4'b0000;
            endcase
         end
         2'd1: begin
            case (pos)
               3'd0:    pattern = 4'b0001;
               3'd1:    pattern = 4'b0010;
               3'd2:    pattern = 4'b0100;
               3'd3:    pattern = 4'b1000;
               default: pattern = 4'b0000;
            endcase
         end
         2'd2: begin
            case (pos)
               3'd0:    pattern = 4'b1000;
               3'd1:    pattern = 4'b0100;
               3'd2:    pattern = 4'b0010;
               3'd3:    pattern = 4'b0001;
               3'd4:    pattern = 4'b0010;
               3'd5:    pattern = 4'b0100;
               default: pattern = 4'b0000;
            endcase
         end
         default: begin
            case (pos)
               3'd0:    pattern = 4'b1111;
               default: pattern = 4'b0000;
            endcase
         end
      endcase
   end

   // Prescaler, step divider and position. A mode change restarts the
   // whole timing chain and takes priority over a coincident step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_cnt <= 24'd0;
         step_cnt <= 2'd0;
         pos      <= 3'd0;
      end else if (key_mode) begin
         base_cnt <= 24'd0;
         step_cnt <= 2'd0;
         pos      <= 3'd0;
      end else if (run) begin
         base_cnt <= base_tick ? 24'd0 : base_cnt + 24'd1;
         if (step_fire) begin
            step_cnt <= 2'd0;
            pos      <= pos_adv;
         end else if (base_tick) begin
            step_cnt <= step_cnt + 2'd1;
         end
      end
   end

   // Mode, speed and pause state; keys act on the edge that samples them,
   // and pause uses the pre-toggle value so a coincident step still lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode   <= 2'd0;
         speed  <= 2'd0;
         paused <= 1'b0;
      end else begin
         if (key_mode)
            mode <= mode + 2'd1;
         if (key_up && !key_dn && speed != 2'd3)
            speed <= speed + 2'd1;
         else if (key_dn && !key_up && speed != 2'd0)
            speed <= speed - 2'd1;
         paused <= paused ^ key_pause;
      end
   end

   // Registered LED drive, one cycle behind the mode/position registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         led <= 4'b0000;
      else
         led <= pattern;
   end

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_seq_ctrl
//  Description : Directed self-checking bench for led_seq_ctrl, TICK_BASE=4.
//                Expected LED transitions (value, cycle) are queued as the
//                stimulus is written and popped as the LED output changes.
//                Cycle n is the interval after the n-th rising edge that
//                follows reset release; led lags pos/mode by one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_mode = 1'b0;
   logic       key_up = 1'b0;
   logic       key_dn = 1'b0;
   logic       key_pause = 1'b0;
   logic [3:0] led;
   logic [1:0] mode;
   logic [1:0] speed;
   logic       paused;

   led_seq_ctrl #(.TICK_BASE(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_mode  (key_mode),
      .key_up    (key_up),
      .key_dn    (key_dn),
      .key_pause (key_pause),
      .led       (led),
      .mode      (mode),
      .speed     (speed),
      .paused    (paused)
   );

   always #5 clk = ~clk;

   // Rising edges since reset release.
   int cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   typedef struct {
      logic [3:0] val;
      int         at;
   } ev_t;

   ev_t        sb[$];
   int         n_checks = 0;
   int         n_fail = 0;
   logic [3:0] last_led = 4'b0000;

   localparam logic [3:0] K_MODE  = 4'b0001;
   localparam logic [3:0] K_UP    = 4'b0010;
   localparam logic [3:0] K_DN    = 4'b0100;
   localparam logic [3:0] K_PAUSE = 4'b1000;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at every falling edge: any LED change must match the queue head.
   task automatic mon();
      ev_t e;
      if (led !== last_led) begin
         if (sb.size() == 0) begin
            chk("led_unexpected_change", 32'(led), 32'(last_led));
         end else begin
            e = sb.pop_front();
            chk("led_value", 32'(led), 32'(e.val));
            chk("led_cycle", 32'(cyc), 32'(e.at));
         end
         last_led = led;
      end
   endtask

   task automatic expect_led(input logic [3:0] v, input int at);
      ev_t e;
      e.val = v;
      e.at  = at;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(negedge clk);
         mon();
      end
   endtask

   // Hold the given keys high for exactly the edge ending cycle c.
   task automatic press(input int c, input logic [3:0] keys);
      wait_cyc(c);
      {key_pause, key_dn, key_up, key_mode} = keys;
      @(negedge clk);
      mon();
      {key_pause, key_dn, key_up, key_mode} = 4'b0000;
   endtask

   task automatic end_phase(input int n);
      wait_cyc(n);
      chk("queue_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_led",    32'(led),    32'h0);
      chk("rst_mode",   32'(mode),   32'h0);
      chk("rst_speed",  32'(speed),  32'h0);
      chk("rst_paused", 32'(paused), 32'h0);
      sb.delete();
      last_led = 4'b0000;
      rst_n = 1'b1;
   endtask

   initial begin
      // Default run: speed 0, a step every 16 cycles, first in cycle 15.
      do_reset();
      expect_led(4'b1000, 1);
      expect_led(4'b0100, 17);
      expect_led(4'b0010, 33);
      expect_led(4'b0001, 49);
      expect_led(4'b1000, 65);
      end_phase(70);
      chk("p1_mode",  32'(mode),  32'd0);
      chk("p1_speed", 32'(speed), 32'd0);

      // Speed saturation: 5x up -> 3 (steps every 4), 5x down -> 0.
      do_reset();
      expect_led(4'b1000, 1);
      expect_led(4'b0100, 5);
      expect_led(4'b0010, 9);
      expect_led(4'b0001, 13);
      expect_led(4'b1000, 17);
      expect_led(4'b0100, 21);
      expect_led(4'b0010, 25);
      expect_led(4'b0001, 41);
      expect_led(4'b1000, 57);
      expect_led(4'b0100, 73);
      for (int i = 0; i < 5; i++) press(i, K_UP);
      chk("speed_sat_hi", 32'(speed), 32'd3);
      for (int i = 0; i < 5; i++) press(26 + i, K_DN);
      chk("speed_sat_lo", 32'(speed), 32'd0);
      press(74, K_UP | K_DN);
      chk("speed_up_dn_same", 32'(speed), 32'd0);
      end_phase(80);

      // Mode cycling, ping-pong wrap, blink, back to run-left.
      do_reset();
      expect_led(4'b1000, 1);
      expect_led(4'b0001, 2);
      expect_led(4'b1000, 3);
      expect_led(4'b0100, 7);
      expect_led(4'b0010, 11);
      expect_led(4'b0001, 15);
      expect_led(4'b0010, 19);
      expect_led(4'b0100, 23);
      expect_led(4'b1000, 27);
      press(0, K_MODE);
      press(1, K_MODE);
      chk("mode_two", 32'(mode), 32'd2);
      for (int i = 0; i < 3; i++) press(2 + i, K_UP);
      chk("p3_speed", 32'(speed), 32'd3);
      expect_led(4'b1111, 30);
      expect_led(4'b0000, 34);
      expect_led(4'b1111, 38);
      expect_led(4'b0000, 42);
      expect_led(4'b1111, 46);
      press(28, K_MODE);
      chk("mode_three", 32'(mode), 32'd3);
      // Pressed off a tick: base_cnt must restart so the next step is 4 later.
      expect_led(4'b1000, 48);
      expect_led(4'b0100, 52);
      press(46, K_MODE);
      chk("mode_wrap", 32'(mode), 32'd0);
      end_phase(54);

      // Pause at 0010, hold, resume from held counters, mode/step collision.
      do_reset();
      expect_led(4'b1000, 1);
      expect_led(4'b0100, 5);
      expect_led(4'b0010, 9);
      for (int i = 0; i < 3; i++) press(i, K_UP);
      press(10, K_PAUSE);
      chk("paused_set", 32'(paused), 32'd1);
      wait_cyc(110);
      chk("paused_led_hold", 32'(led), 32'b0010);
      chk("paused_still", 32'(paused), 32'd1);
      expect_led(4'b0001, 114);
      expect_led(4'b1000, 118);
      expect_led(4'b0100, 122);
      press(111, K_PAUSE);
      chk("paused_clr", 32'(paused), 32'd0);
      // Cycle 124 is a step cycle; the mode change must win with pos = 0.
      expect_led(4'b0001, 126);
      expect_led(4'b0010, 130);
      press(124, K_MODE);
      chk("collide_mode", 32'(mode), 32'd1);
      end_phase(132);

      // Mode change while paused, then asynchronous reset between edges.
      do_reset();
      expect_led(4'b1000, 1);
      expect_led(4'b0001, 2);
      press(0, K_MODE);
      press(1, K_PAUSE);
      chk("p5_paused", 32'(paused), 32'd1);
      expect_led(4'b1000, 7);
      press(5, K_MODE);
      chk("p5_mode", 32'(mode), 32'd2);
      chk("p5_paused_kept", 32'(paused), 32'd1);
      press(7, K_UP);
      press(8, K_UP);
      chk("p5_speed", 32'(speed), 32'd2);
      end_phase(20);
      chk("p5_led_frozen", 32'(led), 32'b1000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_led",    32'(led),    32'h0);
      chk("async_mode",   32'(mode),   32'h0);
      chk("async_speed",  32'(speed),  32'h0);
      chk("async_paused", 32'(paused), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
